hdmi_axi_read_master: RTL and testbench

- AXI4 read master that executes the read requests produced by the HDMI frame address generator (`kick` / `read_addr` / `read_num` / `busy` handshake).
- Splits each request into AXI4 INCR bursts and streams returned pixel words into the HDMI line FIFO.
- Sits between the address generator and the DDR interconnect. It has one burst outstanding at a time.

---
 rtl/hdmi_axi_read_master_if.sv | 38 +++
 rtl/hdmi_axi_read_master.sv | 183 ++++++++++++++++++
 tb/tb_hdmi_axi_read_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_axi_read_master_if.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_axi_read_master_if
// Purpose  : AXI4 read-address / read-data channel bundle for the HDMI reader.
// Revision : 1.0
// ============================================================================
interface hdmi_axi_read_master_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_axi_read_master
// Purpose  : Splits frame read requests into 4 KB-safe AXI4 INCR bursts and
//            streams the returned pixel words into the HDMI line FIFO.
// Revision : 1.0
// ============================================================================
module hdmi_axi_read_master #(
    parameter int MAX_BURST  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    kick,
    input  wire  [31:0]            read_addr,
    input  wire  [31:0]            read_num,
    output logic                   busy,
    hdmi_axi_read_master_if.master axi,
    output logic [DATA_WIDTH-1:0]  fifo_din,
    output logic                   fifo_we,
    input  wire                    fifo_full,
    output logic                   err
);

    localparam int          c_bytes  = DATA_WIDTH / 8;
    localparam int          c_bshift = $clog2(c_bytes);
    localparam logic [31:0] c_max    = 32'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_AR   = 3'd2,
        S_R    = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [31:0]     r_addr;
    logic [31:0]     r_remain;
    logic [31:0]     r_len;
    logic [8:0]      r_beat_cnt;
    logic [31:0]     r_araddr;
    logic [7:0]      r_arlen;
    logic            r_arvalid;
    logic            r_err;

    logic [12:0]     w_span;
    logic [31:0]     w_bound;
    logic [31:0]     w_len;
    logic [31:0]     w_remain_next;
    logic            w_beat;
    logic            w_rready;
    logic [DATA_WIDTH-1:0] w_din;

    // Beats left before the next 4 KB page; addr_r is always word aligned.
    assign w_span        = 13'h1000 - {1'b0, r_addr[11:0]};
    assign w_bound       = {19'd0, w_span} >> c_bshift;
    assign w_remain_next = r_remain - r_len;

    always_comb begin
        w_len = r_remain;
        if (c_max < w_len) begin
            w_len = c_max;
        end
        if (w_bound < w_len) begin
            w_len = w_bound;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rready     = 1'b0;
        w_beat       = 1'b0;
        w_din        = '0;
        case (r_state)
            S_IDLE: begin
                if (kick) begin
                    w_state_next = (read_num == 32'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = S_AR;
            end
            S_AR: begin
                if (axi.m_axi_arready) begin
                    w_state_next = S_R;
                end
            end
            S_R: begin
                w_rready = ~fifo_full;
                if (axi.m_axi_rvalid && !fifo_full) begin
                    w_beat = 1'b1;
                    w_din  = axi.m_axi_rdata;
                    // Burst end is decided by our own beat count, never by rlast.
                    if (r_beat_cnt == 9'd1) begin
                        w_state_next = (w_remain_next != 32'd0) ? S_CALC : S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= 32'd0;
            r_remain   <= 32'd0;
            r_len      <= 32'd0;
            r_beat_cnt <= 9'd0;
            r_araddr   <= 32'd0;
            r_arlen    <= 8'd0;
            r_arvalid  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (kick) begin
                        r_addr   <= read_addr;
                        r_remain <= read_num;
                    end
                end
                S_CALC: begin
                    r_len     <= w_len;
                    r_araddr  <= r_addr;
                    r_arlen   <= 8'(w_len - 32'd1);
                    r_arvalid <= 1'b1;
                end
                S_AR: begin
                    if (axi.m_axi_arready) begin
                        r_arvalid  <= 1'b0;
                        r_beat_cnt <= 9'(r_len);
                    end
                end
                S_R: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt - 9'd1;
                        if ((axi.m_axi_rresp != 2'b00) ||
                            (axi.m_axi_rlast != (r_beat_cnt == 9'd1))) begin
                            r_err <= 1'b1;
                        end
                        if (r_beat_cnt == 9'd1) begin
                            r_addr   <= r_addr + (r_len << c_bshift);
                            r_remain <= w_remain_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy              = (r_state != S_IDLE);
    assign err               = r_err;
    assign fifo_we           = w_beat;
    assign fifo_din          = w_din;

    assign axi.m_axi_araddr  = r_araddr;
    assign axi.m_axi_arlen   = r_arlen;
    assign axi.m_axi_arsize  = 3'(c_bshift);
    assign axi.m_axi_arburst = 2'b01;
    assign axi.m_axi_arcache = 4'b0011;
    assign axi.m_axi_arprot  = 3'b000;
    assign axi.m_axi_arvalid = r_arvalid;
    assign axi.m_axi_rready  = w_rready;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_axi_read_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_axi_read_master
// Purpose  : Randomized bench with a burst/data reference model and AXI slave.
// Revision : 1.0
// ============================================================================
module tb_hdmi_axi_read_master;
    localparam int MAX_BURST  = 64;
    localparam int DATA_WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kick = 1'b0;
    logic [31:0] read_addr = 32'd0;
    logic [31:0] read_num = 32'd0;
    logic        fifo_full;
    logic        busy;
    logic        fifo_we;
    logic        err;
    logic [31:0] fifo_din;

    hdmi_axi_read_master_if #(.DATA_WIDTH(DATA_WIDTH)) axi ();

    hdmi_axi_read_master #(.MAX_BURST(MAX_BURST), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk(clk), .rst(rst), .kick(kick), .read_addr(read_addr),
        .read_num(read_num), .busy(busy), .axi(axi), .fifo_din(fifo_din),
        .fifo_we(fifo_we), .fifo_full(fifo_full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    int          checks = 0;
    int          errors = 0;
    burst_t      exp_bursts[$];
    burst_t      ar_log[$];
    logic [31:0] exp_data[$];
    int          m_phase = 0;
    int          m_writes_left = 0;
    logic        m_err = 1'b0;
    int          wr_count = 0;
    int          busy_cycles = 0;
    int          stall_cycles = 0;
    int          ar_seen_total = 0;
    int          rst_count = 0;
    logic        ar_fire = 1'b0;
    logic        r_fire = 1'b0;
    logic [31:0] fire_addr = 32'd0;
    logic [7:0]  fire_len = 8'd0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_araddr = 32'd0;
    logic [7:0]  prev_arlen = 8'd0;

    int          s_left = 0;
    int          s_beats = 0;
    logic [31:0] s_addr = 32'd0;
    bit          ar_rand = 0;
    bit          r_rand = 0;
    bit          ff_rand = 0;
    int          stall_end = 0;
    int          inj_resp_beat = -1;
    int          inj_rlast_beat = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: split into min(remain, MAX_BURST, beats-to-4KB) bursts.
    task automatic model_request(input logic [31:0] a0, input logic [31:0] n0);
        logic [31:0] a;
        logic [31:0] r;
        logic [31:0] len;
        logic [31:0] bound;
        burst_t      b;
        a = a0;
        r = n0;
        for (int i = 0; i < int'(n0); i++) exp_data.push_back(mem_word(a0 + 32'(4 * i)));
        while (r != 0) begin
            bound = (32'h1000 - {20'd0, a[11:0]}) / 4;
            len = r;
            if (len > MAX_BURST) len = MAX_BURST;
            if (len > bound) len = bound;
            b.addr = a;
            b.len  = 8'(len - 1);
            exp_bursts.push_back(b);
            a = a + len * 4;
            r = r - len;
        end
        m_writes_left = int'(n0);
        m_phase = (n0 == 0) ? 2 : 1;
    endtask

    always @(negedge clk) begin
        burst_t b;
        if (rst) begin
            exp_bursts.delete();
            exp_data.delete();
            m_phase = 0;
            m_writes_left = 0;
            m_err = 1'b0;
            ar_fire = 1'b0;
            r_fire = 1'b0;
            prev_stall = 1'b0;
            rst_count++;
        end else begin
            check("busy", busy, m_phase != 0);
            check("err", err, m_err);
            check("rready", axi.m_axi_rready, (s_left > 0) && !fifo_full);
            check("fifo_we", fifo_we, axi.m_axi_rvalid && axi.m_axi_rready);
            if (m_phase == 0) check("arvalid_idle", axi.m_axi_arvalid, 0);
            if (busy) busy_cycles++;
            if (prev_stall) begin
                check("arvalid_hold", axi.m_axi_arvalid, 1);
                check("araddr_hold", axi.m_axi_araddr, prev_araddr);
                check("arlen_hold", axi.m_axi_arlen, prev_arlen);
            end
            if (fifo_we) begin
                wr_count++;
                check("fifo_queue_nonempty", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) check("fifo_din", fifo_din, exp_data.pop_front());
                if (m_writes_left > 0) m_writes_left--;
            end
            ar_fire = axi.m_axi_arvalid && axi.m_axi_arready;
            r_fire  = axi.m_axi_rvalid && axi.m_axi_rready;
            if (axi.m_axi_arvalid) ar_seen_total++;
            if (ar_fire) begin
                fire_addr = axi.m_axi_araddr;
                fire_len  = axi.m_axi_arlen;
                b.addr = axi.m_axi_araddr;
                b.len  = axi.m_axi_arlen;
                ar_log.push_back(b);
                check("ar_queue_nonempty", exp_bursts.size() != 0, 1);
                if (exp_bursts.size() != 0) begin
                    b = exp_bursts.pop_front();
                    check("araddr", axi.m_axi_araddr, b.addr);
                    check("arlen", axi.m_axi_arlen, b.len);
                end
                check("arsize", axi.m_axi_arsize, 2);
                check("arburst", axi.m_axi_arburst, 1);
                check("arcache", axi.m_axi_arcache, 3);
                check("arprot", axi.m_axi_arprot, 0);
            end
            if (axi.m_axi_arvalid && !axi.m_axi_arready) stall_cycles++;
            prev_stall  = axi.m_axi_arvalid && !axi.m_axi_arready;
            prev_araddr = axi.m_axi_araddr;
            prev_arlen  = axi.m_axi_arlen;
            if (r_fire) begin
                if (axi.m_axi_rresp != 2'b00) m_err = 1'b1;
                if (axi.m_axi_rlast != (s_left == 1)) m_err = 1'b1;
            end
            case (m_phase)
                0: if (kick) model_request(read_addr, read_num);
                1: if (fifo_we && m_writes_left == 0) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
    end

    // AXI slave: one burst at a time, data = mem_word(byte address).
    initial begin
        int seen_rst;
        seen_rst = 0;
        fifo_full = 1'b0;
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rdata   = '0;
        axi.m_axi_rresp   = 2'b00;
        axi.m_axi_rlast   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (seen_rst != rst_count) begin
                seen_rst = rst_count;
                s_left = 0;
                axi.m_axi_arready = 1'b0;
                axi.m_axi_rvalid  = 1'b0;
                axi.m_axi_rlast   = 1'b0;
                axi.m_axi_rresp   = 2'b00;
                fifo_full = 1'b0;
            end else begin
                if (r_fire) begin
                    s_left--;
                    s_beats++;
                    s_addr = s_addr + 32'd4;
                end
                if (ar_fire) begin
                    s_left = int'(fire_len) + 1;
                    s_addr = fire_addr;
                end
                if (ar_seen_total < stall_end) axi.m_axi_arready = 1'b0;
                else axi.m_axi_arready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (!(axi.m_axi_rvalid && !r_fire)) begin
                    if (s_left > 0 && (!r_rand || $urandom_range(0, 2) != 0)) begin
                        axi.m_axi_rvalid = 1'b1;
                        axi.m_axi_rdata  = mem_word(s_addr);
                        axi.m_axi_rlast  = (s_left == 1) || (s_beats == inj_rlast_beat);
                        axi.m_axi_rresp  = (s_beats == inj_resp_beat) ? 2'b10 : 2'b00;
                    end else begin
                        axi.m_axi_rvalid = 1'b0;
                        axi.m_axi_rlast  = 1'b0;
                    end
                end
                fifo_full = ff_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
        end
    end

    task automatic wait_idle(input int limit);
        bit done;
        done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            if (m_phase == 0) done = 1;
        end
        check("idle_timeout", done, 1);
    endtask

    task automatic send_kick(input logic [31:0] a, input logic [31:0] n);
        @(posedge clk);
        #1;
        read_addr = a;
        read_num  = n;
        kick      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        kick = 1'b0;
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] n, input int limit);
        send_kick(a, n);
        wait_idle(limit);
        @(negedge clk);
        check("data_drained", exp_data.size(), 0);
        check("bursts_drained", exp_bursts.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int base_log;
        int base_wr;
        int base_busy;
        int base_stall;
        bit reached;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_arvalid", axi.m_axi_arvalid, 0);
        check("rst_araddr", axi.m_axi_araddr, 0);
        check("rst_arlen", axi.m_axi_arlen, 0);
        check("rst_fifo_din", fifo_din, 0);
        check("rst_rready", axi.m_axi_rready, 0);

        base_log = ar_log.size();
        base_wr  = wr_count;
        run_req(32'h0, 32'd256, 3000);
        check("t1_bursts", ar_log.size() - base_log, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_araddr", ar_log[base_log + i].addr, 32'h100 * i);
            check("t1_arlen", ar_log[base_log + i].len, 63);
        end
        check("t1_writes", wr_count - base_wr, 256);

        base_log = ar_log.size();
        run_req(32'hFC0, 32'd32, 1000);
        check("t2_bursts", ar_log.size() - base_log, 2);
        check("t2_addr0", ar_log[base_log].addr, 32'hFC0);
        check("t2_len0", ar_log[base_log].len, 15);
        check("t2_addr1", ar_log[base_log + 1].addr, 32'h1000);
        check("t2_len1", ar_log[base_log + 1].len, 15);

        ff_rand = 1;
        r_rand  = 1;
        base_wr = wr_count;
        run_req(32'h2000, 32'd64, 3000);
        check("t3_writes", wr_count - base_wr, 64);
        ff_rand = 0;
        r_rand  = 0;

        base_stall = stall_cycles;
        base_log   = ar_log.size();
        stall_end  = ar_seen_total + 10;
        run_req(32'h3000, 32'd16, 1000);
        check("t4_stall_cycles", stall_cycles - base_stall, 10);
        check("t4_araddr", ar_log[base_log].addr, 32'h3000);

        inj_resp_beat = s_beats + 2;
        base_wr = wr_count;
        run_req(32'h4000, 32'd16, 1000);
        check("t5_err_resp", err, 1);
        check("t5_writes", wr_count - base_wr, 16);
        do_reset();
        @(negedge clk);
        check("t5_err_cleared", err, 0);
        inj_rlast_beat = s_beats + 2;
        run_req(32'h5000, 32'd16, 1000);
        check("t5_err_rlast", err, 1);
        run_req(32'h5800, 32'd8, 1000);
        check("t5_err_sticky", err, 1);
        do_reset();

        base_busy = busy_cycles;
        base_log  = ar_log.size();
        run_req(32'h6000, 32'd0, 100);
        check("t6_busy_cycles", busy_cycles - base_busy, 1);
        check("t6_no_ar", ar_log.size() - base_log, 0);

        base_wr = wr_count;
        send_kick(32'h7000, 32'd64);
        reached = 0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk);
            if (wr_count - base_wr >= 5) reached = 1;
        end
        check("t7_reached_mid", reached, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t7_busy", busy, 0);
        check("t7_arvalid", axi.m_axi_arvalid, 0);
        check("t7_rready", axi.m_axi_rready, 0);

        for (int k = 0; k < 5; k++) begin
            ar_rand = 1'($urandom_range(0, 1));
            r_rand  = 1'($urandom_range(0, 1));
            ff_rand = 1'($urandom_range(0, 1));
            run_req($urandom & 32'h0001_FFFC, 32'($urandom_range(1, 300)), 20000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
